// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-buffer types: occupancy states and default field widths.
package cpu_pipe_pkg;

  localparam int PC_W_DEF   = 32;
  localparam int INST_W_DEF = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    FULL  = 2'd3
  } buf_state_e;

endpackage

// File: rtl/id_inbuf_if.sv
// IF->ID->EXE handshake bundle for the decode input buffer.
interface id_inbuf_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              if_to_id_valid;
    logic [PC_W-1:0]   if_pc;
    logic [INST_W-1:0] if_inst;
    logic              id_allow_in;
    logic              id_ready_go;
    logic              exe_allow_in;
    logic              id_flush;
    logic              id_valid;
    logic [PC_W-1:0]   id_pc;
    logic [INST_W-1:0] id_inst;
    logic              id_to_exe_valid;

    modport master (
        output if_to_id_valid, if_pc, if_inst, id_ready_go, exe_allow_in, id_flush,
        input  id_allow_in, id_valid, id_pc, id_inst, id_to_exe_valid
    );

    modport slave (
        input  if_to_id_valid, if_pc, if_inst, id_ready_go, exe_allow_in, id_flush,
        output id_allow_in, id_valid, id_pc, id_inst, id_to_exe_valid
    );
endinterface

// File: rtl/id_inbuf_ctrl.sv
// Occupancy FSM of the ID input buffer; emits data-register load enables.
// ID_INBUF_SKID_EN selects the two-entry skid variant (EMPTY/ONE/TWO).
module id_inbuf_ctrl
    import cpu_pipe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic if_to_id_valid,
    input  logic id_ready_go,
    input  logic exe_allow_in,
    input  logic id_flush,
    output logic head_valid,
    output logic allow_in,
    output logic to_exe_valid,
`ifdef ID_INBUF_SKID_EN
    output logic load_skid,
    output logic load_head_skid,
`endif
    output logic load_head_in
);

    buf_state_e state;
    logic       accept;
    logic       dequeue;

    // Outputs are forced idle while rst is held so nothing leaks during reset.
    assign head_valid   = !rst && (state != EMPTY);
    assign to_exe_valid = head_valid && id_ready_go && !id_flush;
`ifdef ID_INBUF_SKID_EN
    assign allow_in     = !rst && (state != TWO);
`else
    assign allow_in     = !rst && (!head_valid || (id_ready_go && exe_allow_in));
`endif
    assign accept       = if_to_id_valid && allow_in && !id_flush;
    assign dequeue      = to_exe_valid && exe_allow_in;

    assign load_head_in   = accept && ((state == EMPTY) || dequeue);
`ifdef ID_INBUF_SKID_EN
    assign load_skid      = accept && !dequeue && (state == ONE);
    assign load_head_skid = dequeue && (state == TWO);
`endif

    always_ff @(posedge clk) begin
        if (rst || id_flush) begin
            state <= EMPTY;
        end else begin
            unique case (state)
`ifdef ID_INBUF_SKID_EN
                EMPTY: if (accept) state <= ONE;
                ONE: begin
                    if (accept && !dequeue)      state <= TWO;
                    else if (dequeue && !accept) state <= EMPTY;
                end
                TWO:   if (dequeue) state <= ONE;
                default: state <= EMPTY;
`else
                EMPTY: if (accept) state <= FULL;
                FULL:  if (dequeue && !accept) state <= EMPTY;
                default: state <= EMPTY;
`endif
            endcase
        end
    end

endmodule

// File: rtl/id_inbuf.sv
// Decode-stage input buffer between IF and EXE; in-order, flushable.
// Define ID_INBUF_SKID_EN for the two-entry skid buffer, else single entry.
module id_inbuf
    import cpu_pipe_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF
) (
    input logic       clk,
    input logic       rst,
    id_inbuf_if.slave bus
);

    logic              head_valid;
    logic              load_head_in;
    logic [PC_W-1:0]   head_pc_p0;
    logic [INST_W-1:0] head_inst_p0;
`ifdef ID_INBUF_SKID_EN
    logic              load_skid;
    logic              load_head_skid;
    logic [PC_W-1:0]   skid_pc_p0;
    logic [INST_W-1:0] skid_inst_p0;
`endif

    id_inbuf_ctrl u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .if_to_id_valid (bus.if_to_id_valid),
        .id_ready_go    (bus.id_ready_go),
        .exe_allow_in   (bus.exe_allow_in),
        .id_flush       (bus.id_flush),
        .head_valid     (head_valid),
        .allow_in       (bus.id_allow_in),
        .to_exe_valid   (bus.id_to_exe_valid),
`ifdef ID_INBUF_SKID_EN
        .load_skid      (load_skid),
        .load_head_skid (load_head_skid),
`endif
        .load_head_in   (load_head_in)
    );

    // IF -> ID register stage; data is not reset, validity lives in the FSM
    always_ff @(posedge clk) begin
        if (load_head_in) begin
            head_pc_p0   <= bus.if_pc;
            head_inst_p0 <= bus.if_inst;
`ifdef ID_INBUF_SKID_EN
        end else if (load_head_skid) begin
            head_pc_p0   <= skid_pc_p0;
            head_inst_p0 <= skid_inst_p0;
`endif
        end
    end

`ifdef ID_INBUF_SKID_EN
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_pc_p0   <= bus.if_pc;
            skid_inst_p0 <= bus.if_inst;
        end
    end
`endif

    assign bus.id_valid = head_valid;
    assign bus.id_pc    = head_valid ? head_pc_p0   : '0;
    assign bus.id_inst  = head_valid ? head_inst_p0 : '0;

endmodule
